// File: rtl/residual_calc.sv
// ============================================================================
// residual_calc
// Re-reads stored (x, y) samples, streams residuals y - (B0 + B1*x) and
// accumulates the sum of absolute residuals over one pass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module residual_calc #(
    parameter int N_SAMPLES = 150,
    parameter int ADDR_W    = 8,
    parameter int SAE_W     = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [19:0]       B0,
    input  logic [19:0]       B1,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [19:0]       x_in,
    input  logic [19:0]       y_in,
    output logic [19:0]       err,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_idx,
    output logic [SAE_W-1:0]  sae,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SAMPLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        COMPUTE = 3'd2,
        EMIT    = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  count;
    logic signed [19:0] b0_lat;
    logic signed [19:0] b1_lat;

    logic signed [39:0] prod;
    logic [19:0]        yhat;
    logic [19:0]        err_next;
    logic [19:0]        err_abs;
    logic               unused_prod_bits;

    // Q10.10 * Q10.10 = Q20.20; keep the Q10.10 window, dropping fraction bits (floor).
    assign prod             = b1_lat * $signed(x_in);
    assign yhat             = prod[29:10] + b0_lat;
    assign err_next         = y_in - yhat;
    assign unused_prod_bits = ^{prod[39:30], prod[9:0]};

    // Most negative residual maps to an unsigned 0x80000 magnitude.
    assign err_abs = err[19] ? (~err + 20'd1) : err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            b0_lat    <= '0;
            b1_lat    <= '0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            err       <= '0;
            err_valid <= 1'b0;
            err_idx   <= '0;
            sae       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_rd    <= 1'b0;
            err_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        b0_lat   <= $signed(B0);
                        b1_lat   <= $signed(B1);
                        count    <= '0;
                        sae      <= '0;
                        mem_addr <= '0;
                        mem_rd   <= 1'b1;
                        busy     <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    state <= COMPUTE;
                end
                COMPUTE: begin
                    err       <= err_next;
                    err_idx   <= count;
                    err_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    sae <= sae + {{(SAE_W-20){1'b0}}, err_abs};
                    if (count == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        count    <= count + 1'b1;
                        mem_addr <= count + 1'b1;
                        mem_rd   <= 1'b1;
                        state    <= FETCH;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
